conv_bram_1d_result_reader: RTL

//  Read-side counterpart of the 1-D conv datapath's result-RAM write port.
//  - On start, reads all RESULT_W result words from the result BRAM (1-cycle read latency).
//  - Streams the words out in address order on a valid/ready interface, with a last flag.
//  - A 2-entry buffer absorbs RAM latency, so backpressure never loses or duplicates data.
//  - Sits between the result BRAM and the downstream consumer (next layer / host DMA).

---
 rtl/conv_bram_1d_result_reader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/conv_bram_1d_result_reader.sv
// conv_bram_1d_result_reader: streams the 1-D conv result RAM out on a
// valid/ready port after a start pulse, absorbing RAM read latency in a 2-entry FIFO.
//
// Ports:
//   clk, reset      - clock, synchronous active-low reset
//   start           - begin a readout pass (honoured only when idle)
//   busy, done      - pass in progress / 1-cycle completion pulse
//   result_rden     - result RAM read enable
//   result_rdaddr   - result RAM read address
//   result_rddata   - result RAM data (one cycle after rden)
//   out_data        - streamed result word
//   out_valid       - out_data valid
//   out_ready       - consumer ready
//   out_last        - marks the word from the final address
module conv_bram_1d_result_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 32,
    parameter int FILTER_L   = 3,
    parameter int STRIDE_W   = 1,
    localparam int RESULT_W  = (IMG_W - FILTER_L) / STRIDE_W + 1,
    localparam int RESULT_RAM_ADDR_WIDTH =
        (RESULT_W > 1) ? $clog2(RESULT_W) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             result_rden,
    output logic [RESULT_RAM_ADDR_WIDTH-1:0] result_rdaddr,
    input  logic [DATA_WIDTH-1:0]            result_rddata,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last
);

    localparam logic [RESULT_RAM_ADDR_WIDTH-1:0] LAST_ADDR =
        RESULT_RAM_ADDR_WIDTH'(RESULT_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t                           state;
    logic [RESULT_RAM_ADDR_WIDTH-1:0] rd_cnt;
    logic                             inflight;
    logic                             inflight_last;
    logic [1:0]                       fifo_cnt;
    logic [DATA_WIDTH-1:0]            d0;
    logic [DATA_WIDTH-1:0]            d1;
    logic                             l0;
    logic                             l1;
    logic                             pop;
    logic                             push;
    logic                             rd_is_last;

    assign out_valid     = (fifo_cnt != 2'd0);
    assign out_data      = d0;
    assign out_last      = l0;
    assign result_rdaddr = rd_cnt;
    assign pop           = out_valid & out_ready;
    assign push          = inflight;
    assign rd_is_last    = (rd_cnt == LAST_ADDR);

    // Count words already buffered or on their way from the RAM, net of
    // the word leaving this cycle, so the FIFO can never be overrun.
    assign result_rden = (state == READ) &&
        (({1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop}) < 3'd2);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            rd_cnt        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            fifo_cnt      <= 2'd0;
            d0            <= '0;
            d1            <= '0;
            l0            <= 1'b0;
            l1            <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            inflight      <= result_rden;
            inflight_last <= result_rden && rd_is_last;
            done          <= 1'b0;

            if (result_rden && !rd_is_last)
                rd_cnt <= rd_cnt + RESULT_RAM_ADDR_WIDTH'(1);

            // Head always lives in entry 0; entry 1 is the spill slot.
            case ({push, pop})
                2'b10: begin
                    if (fifo_cnt == 2'd0) begin
                        d0 <= result_rddata;
                        l0 <= inflight_last;
                    end else begin
                        d1 <= result_rddata;
                        l1 <= inflight_last;
                    end
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    d0       <= d1;
                    l0       <= l1;
                    fifo_cnt <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        d0 <= result_rddata;
                        l0 <= inflight_last;
                    end else begin
                        d0 <= d1;
                        l0 <= l1;
                        d1 <= result_rddata;
                        l1 <= inflight_last;
                    end
                end
                default: ;
            endcase

            case (state)
                IDLE: begin
                    // busy stays up through the done cycle, so a new
                    // start is only taken once the pulse has gone.
                    if (start && !busy) begin
                        state  <= READ;
                        busy   <= 1'b1;
                        rd_cnt <= '0;
                    end else if (done) begin
                        busy <= 1'b0;
                    end
                end
                READ: begin
                    if (result_rden && rd_is_last)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && l0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_fifo_bound: assert property (
        @(posedge clk) disable iff (!reset) fifo_cnt <= 2'd2
    );

endmodule
